// File: rtl/cu_pkg.sv
// cu_pkg: shared control-unit types.
//   mem_req_source_sel : address source for a data transfer (existing control-unit type)
//   mem_access         : kind of data transfer requested by a decoded instruction
//   ofs_state          : operand_fetch_sequencer FSM states
package cu_pkg;

    typedef enum logic [1:0] {
        value_from_pc       = 2'd0,
        value_from_reg_file = 2'd1,
        value_from_imm      = 2'd2
    } mem_req_source_sel;

    typedef enum logic [1:0] {
        no_access    = 2'd0,
        read_access  = 2'd1,
        write_access = 2'd2
    } mem_access;

    typedef enum logic [1:0] {
        ofs_idle = 2'd0,
        ofs_imm  = 2'd1,
        ofs_data = 2'd2,
        ofs_done = 2'd3
    } ofs_state;

endpackage

// File: rtl/operand_fetch_sequencer_timer.sv
// ofs_wait_timer: counts consecutive cycles a bus request waits for ack.
//   clk, nrst : clock, asynchronous active-low reset
//   clear     : restart the count (new request issued or ack seen)
//   enable    : a requested transfer is waiting this cycle
//   expired   : this cycle is the WAIT_LIMIT-th consecutive waiting cycle
module ofs_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of waiting cycles already elapsed, so the
    // current waiting cycle is the last allowed one when cnt_q == LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: on a start pulse, fetches 0..MAX_IMM_BYTES
// little-endian immediate bytes from the PC stream, then optionally performs
// a 1- or 2-byte data read or write, with a bounded wait for each bus ack.
//   clk, nrst               : clock, asynchronous active-low reset
//   start                   : request pulse, accepted only while idle
//   imm_bytes               : immediate byte count (clamped to MAX_IMM_BYTES)
//   access, access_two      : data transfer kind and size
//   addr_sel                : data base address source (PC, register file, immediate)
//   pc_in, reg_addr, wdata  : operands latched at start
//   busy, done, error       : status; done/error are one-cycle pulses
//   imm_out, rdata_out      : assembled immediate / read data, low byte first
//   pc_out                  : pc_in + effective imm_bytes
//   mem_*                   : byte-wide request/ack bus
module operand_fetch_sequencer
    import cu_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int MAX_IMM_BYTES = 2,
    parameter int WAIT_LIMIT    = 15
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  start,
    input  logic [$clog2(MAX_IMM_BYTES+1)-1:0]    imm_bytes,
    input  mem_access                             access,
    input  logic                                  access_two,
    input  mem_req_source_sel                     addr_sel,
    input  logic [ADDR_W-1:0]                     pc_in,
    input  logic [ADDR_W-1:0]                     reg_addr,
    input  logic [2*DATA_W-1:0]                   wdata,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [MAX_IMM_BYTES*DATA_W-1:0]       imm_out,
    output logic [2*DATA_W-1:0]                   rdata_out,
    output logic [ADDR_W-1:0]                     pc_out,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic [DATA_W-1:0]                     mem_rdata,
    input  logic                                  mem_ack
);

    localparam int IMM_W = MAX_IMM_BYTES * DATA_W;
    localparam int CNT_W = $clog2(MAX_IMM_BYTES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_IMM_BYTES);

    ofs_state          state_q, state_d;
    logic [CNT_W-1:0]  n_imm_q, n_imm_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    mem_access         access_q, access_d;
    logic              two_q, two_d;
    mem_req_source_sel sel_q, sel_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [2*DATA_W-1:0] wdata_q, wdata_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [CNT_W-1:0]  eff_imm;
    logic [CNT_W-1:0]  idx_next;
    logic              xfer_done;
    logic              timer_expired;

    function automatic logic [ADDR_W-1:0] base_addr(
        input mem_req_source_sel sel,
        input logic [ADDR_W-1:0] pc_post,
        input logic [ADDR_W-1:0] reg_a,
        input logic [IMM_W-1:0]  imm
    );
        case (sel)
            value_from_reg_file: return reg_a;
            value_from_imm:      return ADDR_W'(imm);
            default:             return pc_post;
        endcase
    endfunction

    assign eff_imm   = (imm_bytes > MAX_CNT) ? MAX_CNT : imm_bytes;
    assign idx_next  = idx_q + CNT_W'(1);
    assign xfer_done = mem_req_q && mem_ack;

    ofs_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (!mem_req_q || mem_ack),
        .enable (mem_req_q && !mem_ack),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        n_imm_d     = n_imm_q;
        idx_d       = idx_q;
        access_d    = access_q;
        two_d       = two_q;
        sel_d       = sel_q;
        pc_d        = pc_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        imm_d       = imm_q;
        rdata_d     = rdata_q;
        pc_out_d    = pc_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ofs_idle: begin
                if (start) begin
                    n_imm_d    = eff_imm;
                    access_d   = access;
                    two_d      = access_two;
                    sel_d      = addr_sel;
                    pc_d       = pc_in;
                    reg_addr_d = reg_addr;
                    wdata_d    = wdata;
                    imm_d      = '0;
                    rdata_d    = '0;
                    pc_out_d   = pc_in + ADDR_W'(eff_imm);
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    mem_we_d   = 1'b0;
                    if (eff_imm != '0) begin
                        state_d    = ofs_imm;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_in;
                    end else if (access != no_access) begin
                        // No immediate: the PC source is pc_in itself and the
                        // immediate source reads as zero.
                        state_d     = ofs_data;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = base_addr(addr_sel, pc_in, reg_addr, '0);
                        mem_we_d    = (access == write_access);
                        mem_wdata_d = wdata[DATA_W-1:0];
                    end else begin
                        state_d = ofs_done;
                        done_d  = 1'b1;
                    end
                end
            end

            ofs_imm: begin
                if (xfer_done) begin
                    imm_d[int'(idx_q)*DATA_W +: DATA_W] = mem_rdata;
                    if (idx_next < n_imm_q) begin
                        idx_d      = idx_next;
                        mem_addr_d = pc_q + ADDR_W'(idx_next);
                    end else if (access_q != no_access) begin
                        // Base uses imm_d so the byte arriving now is included
                        // and the data request follows without a bubble.
                        state_d     = ofs_data;
                        idx_d       = '0;
                        mem_addr_d  = base_addr(sel_q, pc_out_q, reg_addr_q, imm_d);
                        mem_we_d    = (access_q == write_access);
                        mem_wdata_d = wdata_q[DATA_W-1:0];
                    end else begin
                        state_d   = ofs_done;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d   = ofs_idle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                end
            end

            ofs_data: begin
                if (xfer_done) begin
                    if (access_q == read_access) begin
                        rdata_d[int'(idx_q)*DATA_W +: DATA_W] = mem_rdata;
                    end
                    if (two_q && (idx_q == '0)) begin
                        idx_d       = idx_next;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = wdata_q[DATA_W +: DATA_W];
                    end else begin
                        state_d   = ofs_done;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        done_d    = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d   = ofs_idle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                end
            end

            ofs_done: begin
                state_d = ofs_idle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ofs_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ofs_idle;
            n_imm_q     <= '0;
            idx_q       <= '0;
            access_q    <= no_access;
            two_q       <= 1'b0;
            sel_q       <= value_from_pc;
            pc_q        <= '0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
            imm_q       <= '0;
            rdata_q     <= '0;
            pc_out_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            n_imm_q     <= n_imm_d;
            idx_q       <= idx_d;
            access_q    <= access_d;
            two_q       <= two_d;
            sel_q       <= sel_d;
            pc_q        <= pc_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            imm_q       <= imm_d;
            rdata_q     <= rdata_d;
            pc_out_q    <= pc_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign imm_out   = imm_q;
    assign rdata_out = rdata_q;
    assign pc_out    = pc_out_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed bench for operand_fetch_sequencer (default parameters:
// 16-bit address, 8-bit data, 2 immediate bytes, 15-cycle wait limit).
module tb_operand_fetch_sequencer;
    import cu_pkg::*;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        imm_bytes = '0;
    mem_access         access = no_access;
    logic              access_two = 1'b0;
    mem_req_source_sel addr_sel = value_from_pc;
    logic [15:0]       pc_in = '0;
    logic [15:0]       reg_addr = '0;
    logic [15:0]       wdata = '0;
    logic              busy, done, error;
    logic [15:0]       imm_out, rdata_out, pc_out;
    logic              mem_req, mem_we;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic              mem_ack = 1'b0;

    int total = 0;
    int bad = 0;

    logic [7:0]  resp [8];
    logic [15:0] log_addr [8];
    logic        log_we [8];
    logic [7:0]  log_wd [8];
    int ri, n_log, n_req, done_cyc, err_cyc, n_done, n_err;

    operand_fetch_sequencer dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .imm_bytes (imm_bytes),
        .access    (access),
        .access_two(access_two),
        .addr_sel  (addr_sel),
        .pc_in     (pc_in),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .imm_out   (imm_out),
        .rdata_out (rdata_out),
        .pc_out    (pc_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse's operands; the current cycle is "cycle 0".
    task automatic do_start(input logic [15:0] pc, input logic [1:0] n,
                            input mem_access acc, input logic two,
                            input mem_req_source_sel sel,
                            input logic [15:0] ra, input logic [15:0] wd);
        pc_in = pc; imm_bytes = n; access = acc; access_two = two;
        addr_sel = sel; reg_addr = ra; wdata = wd; start = 1'b1;
    endtask

    // Bus responder: withholds ack for the first 'stall' requested cycles,
    // then acks every request with the next resp[] byte. Stops at done/error.
    task automatic run(input int max_cyc, input int stall);
        int c;
        int st;
        n_log = 0; n_req = 0; ri = 0; done_cyc = -1; err_cyc = -1;
        n_done = 0; n_err = 0; st = stall;
        tick();
        start = 1'b0;
        c = 1;
        while (c <= max_cyc) begin
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
            if (error) begin
                if (err_cyc < 0) err_cyc = c;
                n_err++;
            end
            if (mem_req) begin
                n_req++;
                if (st > 0) begin
                    st--;
                    mem_ack = 1'b0;
                end else begin
                    mem_ack = 1'b1;
                    mem_rdata = (ri < 8) ? resp[ri] : 8'h00;
                    ri++;
                    if (n_log < 8) begin
                        log_addr[n_log] = mem_addr;
                        log_we[n_log]   = mem_we;
                        log_wd[n_log]   = mem_wdata;
                    end
                    n_log++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (done || error) break;
            tick();
            c++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(); tick();
        total++;
        if ({busy, done, error, mem_req, mem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, error, mem_req, mem_we});
        end
        total++;
        if ({imm_out, rdata_out, pc_out, mem_addr, mem_wdata} !== 72'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {imm_out, rdata_out, pc_out, mem_addr, mem_wdata});
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_imm_fetch();
        resp[0] = 8'h34; resp[1] = 8'h12;
        do_start(16'h1234, 2'd2, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(20, 0);
        total++;
        if (done_cyc !== 3) begin bad++; $display("FAIL imm_done_cycle got=%0d want=3", done_cyc); end
        total++;
        if (n_log !== 2 || log_addr[0] !== 16'h1234 || log_addr[1] !== 16'h1235) begin
            bad++; $display("FAIL imm_addrs got=n%0d %h %h want=n2 1234 1235", n_log, log_addr[0], log_addr[1]);
        end
        total++;
        if (imm_out !== 16'h1234) begin bad++; $display("FAIL imm_value got=%h want=1234", imm_out); end
        total++;
        if (pc_out !== 16'h1236) begin bad++; $display("FAIL imm_pc_out got=%h want=1236", pc_out); end
        tick();
        total++;
        if ({busy, done, mem_req} !== 3'b000) begin
            bad++; $display("FAIL imm_after_done got=%b want=000", {busy, done, mem_req});
        end
    endtask

    task automatic test_read_imm_addr();
        resp[0] = 8'h00; resp[1] = 8'h80; resp[2] = 8'hAA; resp[3] = 8'hBB;
        do_start(16'h2000, 2'd2, read_access, 1'b1, value_from_imm, 16'h0, 16'h0);
        run(20, 0);
        total++;
        if (done_cyc !== 5) begin bad++; $display("FAIL rd_done_cycle got=%0d want=5", done_cyc); end
        total++;
        if (n_log !== 4 || log_addr[2] !== 16'h8000 || log_addr[3] !== 16'h8001) begin
            bad++; $display("FAIL rd_data_addrs got=n%0d %h %h want=n4 8000 8001", n_log, log_addr[2], log_addr[3]);
        end
        total++;
        if (log_we[2] !== 1'b0 || log_we[3] !== 1'b0) begin
            bad++; $display("FAIL rd_we got=%b%b want=00", log_we[2], log_we[3]);
        end
        total++;
        if (rdata_out !== 16'hBBAA) begin bad++; $display("FAIL rd_rdata got=%h want=bbaa", rdata_out); end
        total++;
        if (pc_out !== 16'h2002) begin bad++; $display("FAIL rd_pc_out got=%h want=2002", pc_out); end
        tick();
    endtask

    task automatic test_write_wrap();
        resp[0] = 8'h77;
        do_start(16'hFFFF, 2'd1, write_access, 1'b1, value_from_reg_file, 16'hFFFF, 16'h5566);
        run(20, 0);
        total++;
        if (done_cyc !== 4) begin bad++; $display("FAIL wr_done_cycle got=%0d want=4", done_cyc); end
        total++;
        if (pc_out !== 16'h0000) begin bad++; $display("FAIL wr_pc_out got=%h want=0000", pc_out); end
        total++;
        if (n_log !== 3 || log_addr[0] !== 16'hFFFF || log_we[0] !== 1'b0) begin
            bad++; $display("FAIL wr_fetch got=n%0d %h we%b want=n3 ffff we0", n_log, log_addr[0], log_we[0]);
        end
        total++;
        if (log_addr[1] !== 16'hFFFF || log_we[1] !== 1'b1 || log_wd[1] !== 8'h66) begin
            bad++; $display("FAIL wr_lo got=%h we%b %h want=ffff we1 66", log_addr[1], log_we[1], log_wd[1]);
        end
        total++;
        if (log_addr[2] !== 16'h0000 || log_we[2] !== 1'b1 || log_wd[2] !== 8'h55) begin
            bad++; $display("FAIL wr_hi got=%h we%b %h want=0000 we1 55", log_addr[2], log_we[2], log_wd[2]);
        end
        total++;
        if (imm_out !== 16'h0077 || rdata_out !== 16'h0000) begin
            bad++; $display("FAIL wr_regs got=%h %h want=0077 0000", imm_out, rdata_out);
        end
        tick();
    endtask

    task automatic test_wait_and_clamp();
        resp[0] = 8'h9C;
        do_start(16'h0500, 2'd1, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(30, 3);
        total++;
        if (done_cyc !== 5 || n_log !== 1 || log_addr[0] !== 16'h0500) begin
            bad++; $display("FAIL wait_done got=c%0d n%0d %h want=c5 n1 0500", done_cyc, n_log, log_addr[0]);
        end
        total++;
        if (imm_out !== 16'h009C) begin bad++; $display("FAIL wait_imm got=%h want=009c", imm_out); end
        tick();
        resp[0] = 8'h01; resp[1] = 8'h02;
        do_start(16'h0010, 2'd3, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(20, 0);
        total++;
        if (done_cyc !== 3 || n_log !== 2 || pc_out !== 16'h0012 || imm_out !== 16'h0201) begin
            bad++; $display("FAIL clamp got=c%0d n%0d pc%h imm%h want=c3 n2 pc0012 imm0201",
                            done_cyc, n_log, pc_out, imm_out);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_start(16'h4000, 2'd1, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(40, 1000);
        total++;
        if (err_cyc !== 16 || n_err !== 1) begin
            bad++; $display("FAIL to_error_cycle got=c%0d n%0d want=c16 n1", err_cyc, n_err);
        end
        total++;
        if (done_cyc !== -1 || n_req !== 15) begin
            bad++; $display("FAIL to_no_done got=done%0d req%0d want=done-1 req15", done_cyc, n_req);
        end
        total++;
        if ({busy, mem_req, done} !== 3'b000) begin
            bad++; $display("FAIL to_idle got=%b want=000", {busy, mem_req, done});
        end
        tick();
        total++;
        if ({error, mem_req, busy} !== 3'b000) begin
            bad++; $display("FAIL to_pulse_once got=%b want=000", {error, mem_req, busy});
        end
        resp[0] = 8'h5A;
        do_start(16'h4100, 2'd1, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(20, 0);
        total++;
        if (done_cyc !== 2 || imm_out !== 16'h005A || n_err !== 0) begin
            bad++; $display("FAIL to_recover got=c%0d %h e%0d want=c2 005a e0", done_cyc, imm_out, n_err);
        end
        tick();
    endtask

    task automatic test_busy_and_reset();
        do_start(16'h0100, 2'd0, read_access, 1'b1, value_from_reg_file, 16'h3000, 16'h0);
        tick();
        total++;
        if ({busy, mem_req, mem_we} !== 3'b110 || mem_addr !== 16'h3000) begin
            bad++; $display("FAIL br_first got=%b %h want=110 3000", {busy, mem_req, mem_we}, mem_addr);
        end
        // start stays high with different operands while busy
        pc_in = 16'h7777; imm_bytes = 2'd2; access = no_access; reg_addr = 16'h9999;
        tick();
        start = 1'b0;
        total++;
        if (mem_addr !== 16'h3000 || pc_out !== 16'h0100 || mem_req !== 1'b1) begin
            bad++; $display("FAIL br_ignore got=%h %h %b want=3000 0100 1", mem_addr, pc_out, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        total++;
        if (mem_addr !== 16'h3001 || rdata_out !== 16'h0011) begin
            bad++; $display("FAIL br_second got=%h %h want=3001 0011", mem_addr, rdata_out);
        end
        nrst = 1'b0;
        #1;
        total++;
        if ({busy, done, error, mem_req, mem_we} !== 5'b0 ||
            {imm_out, rdata_out, pc_out, mem_addr, mem_wdata} !== 72'h0) begin
            bad++; $display("FAIL br_async_reset got=%b %h want=0",
                            {busy, done, error, mem_req, mem_we},
                            {imm_out, rdata_out, pc_out, mem_addr, mem_wdata});
        end
        tick();
        nrst = 1'b1;
        tick();
        total++;
        if ({busy, done, error, mem_req} !== 4'b0) begin
            bad++; $display("FAIL br_after_reset got=%b want=0000", {busy, done, error, mem_req});
        end
    endtask

    task automatic test_zero_work();
        do_start(16'hABCD, 2'd0, no_access, 1'b0, value_from_pc, 16'h0, 16'h0);
        run(10, 0);
        total++;
        if (done_cyc !== 1 || n_req !== 0) begin
            bad++; $display("FAIL zero_done got=c%0d req%0d want=c1 req0", done_cyc, n_req);
        end
        total++;
        if (pc_out !== 16'hABCD || imm_out !== 16'h0 || rdata_out !== 16'h0) begin
            bad++; $display("FAIL zero_regs got=%h %h %h want=abcd 0 0", pc_out, imm_out, rdata_out);
        end
        tick();
        total++;
        if ({busy, done, error, mem_req} !== 4'b0) begin
            bad++; $display("FAIL zero_after got=%b want=0000", {busy, done, error, mem_req});
        end
    endtask

    initial begin
        test_reset();
        test_imm_fetch();
        test_read_imm_addr();
        test_write_wrap();
        test_wait_and_clamp();
        test_timeout();
        test_busy_and_reset();
        test_zero_work();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
